// File: rtl/aura_pkg.sv
// Shared definitions for the OPM register-port write scheduler:
// status bit position, FSM encoding, requester IDs and the command word.
package aura_pkg;

   // Bit of the OPM status byte that reports "write in progress".
   localparam int OPM_BUSY_BIT = 7;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      STROBE = 3'd2,
      HOLD   = 3'd3,
      GAP    = 3'd4,
      SETTLE = 3'd5,
      POLL   = 3'd6
   } opm_state_e;

   typedef enum logic {
      REQ_HOST = 1'b0,
      REQ_AUX  = 1'b1
   } req_id_e;

   // One register write: A0 select plus data byte.
   typedef struct packed {
      logic       a0;
      logic [7:0] d;
   } opm_cmd_t;

   // Round-robin helper: when both requesters contend, the one that was
   // not granted last goes first.
   function automatic req_id_e rr_pick(input req_id_e last_req);
      req_id_e pick;
      if (last_req == REQ_HOST) begin
         pick = REQ_AUX;
      end else begin
         pick = REQ_HOST;
      end
      return pick;
   endfunction

endpackage

// File: rtl/opm_cmd_fifo.sv
// Synchronous command FIFO for host register writes. Occupancy is kept as
// an explicit level register; a push into a full FIFO is accepted when the
// same cycle pops, so the FIFO never stalls a back-to-back producer.
module opm_cmd_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 9
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       din,
   output logic [WIDTH-1:0]       dout,
   output logic [$clog2(DEPTH):0] level,
   output logic                   full,
   output logic                   empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [AW:0]      level_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign full  = (level_r == FULL_LVL);
   assign empty = (level_r == {(AW + 1){1'b0}});
   assign level = level_r;
   assign dout  = mem_r[rd_ptr_r];

   // Qualify the raw strobes against the current occupancy.
   always_comb begin
      pop_ok_s  = pop & ~empty;
      push_ok_s = push & (~full | pop_ok_s);
   end

   // Storage array; contents are meaningless until the write pointer covers them.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= din;
      end
   end

   // Pointers wrap naturally at DEPTH (power of two); level tracks occupancy.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         level_r  <= {(AW + 1){1'b0}};
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + {{(AW - 1){1'b0}}, 1'b1};
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + {{(AW - 1){1'b0}}, 1'b1};
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   level_r <= level_r + {{AW{1'b0}}, 1'b1};
            2'b01:   level_r <= level_r - {{AW{1'b0}}, 1'b1};
            default: level_r <= level_r;
         endcase
      end
   end

endmodule

// File: rtl/opm_wr_sched.sv
// YM2151 register-port write scheduler. Host writes are queued in a FIFO,
// an auxiliary requester is arbitrated against it round-robin, and each
// winning entry is issued as a timed CS/WR strobe. Address writes are
// followed by a fixed gap; data writes are followed by a settle delay and
// a status poll on the busy flag. An address write locks the bus to its
// requester until that requester's data write finishes, so address/data
// pairs from different sources never interleave.
module opm_wr_sched
   import aura_pkg::*;
#(
   parameter int FIFO_DEPTH   = 16,
   parameter int WR_CYCLES    = 14,
   parameter int ADDR_GAP     = 4,
   parameter int BUSY_SETTLE  = 14,
   parameter int BUSY_TIMEOUT = 4096
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic                          host_wr_i,
   input  logic                          host_a0_i,
   input  logic [7:0]                    host_d_i,
   output logic                          host_full_o,
   output logic [$clog2(FIFO_DEPTH):0]   host_level_o,
   output logic                          host_ovf_o,
   input  logic                          ovf_clr_i,
   input  logic                          aux_valid_i,
   input  logic                          aux_a0_i,
   input  logic [7:0]                    aux_d_i,
   output logic                          aux_ready_o,
   output logic                          opm_cs_n_o,
   output logic                          opm_wr_n_o,
   output logic                          opm_rd_n_o,
   output logic                          opm_a0_o,
   output logic [7:0]                    opm_d_o,
   input  logic [7:0]                    opm_status_i,
   output logic                          sched_busy_o,
   output logic                          timeout_o
);

   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
   localparam int CNT_W = $clog2(BUSY_TIMEOUT + WR_CYCLES + ADDR_GAP + BUSY_SETTLE);

   localparam logic [CNT_W-1:0] CNT_STROBE = CNT_W'(WR_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_GAP    = CNT_W'(ADDR_GAP - 1);
   localparam logic [CNT_W-1:0] CNT_SETTLE = CNT_W'(BUSY_SETTLE - 1);
   localparam logic [CNT_W-1:0] CNT_POLL   = CNT_W'(BUSY_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);

   // FIFO interface
   opm_cmd_t         fifo_dout_s;
   logic [LVL_W-1:0] fifo_level_s;
   logic             fifo_full_s;
   logic             fifo_empty_s;
   logic             pop_s;
   logic             drop_s;

   // Arbitration
   logic             host_elig_s;
   logic             aux_elig_s;
   logic             grant_s;
   req_id_e          grant_req_s;
   opm_cmd_t         grant_cmd_s;

   // Sequencer state
   opm_state_e       state_r;
   logic [CNT_W-1:0] cnt_r;
   opm_cmd_t         cur_cmd_r;
   req_id_e          cur_req_r;
   req_id_e          last_req_r;
   logic             lock_r;
   req_id_e          lock_owner_r;
   logic             cnt_zero_s;
   logic             status_busy_s;
   logic             timeout_set_s;
   logic             unused_status_s;

   // Registered bus and handshake outputs
   logic             cs_n_r;
   logic             wr_n_r;
   logic             rd_n_r;
   logic             a0_r;
   logic [7:0]       d_r;
   logic             aux_ready_r;
   logic             ovf_r;
   logic             timeout_r;

   opm_cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (9)
   ) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (host_wr_i),
      .pop    (pop_s),
      .din    ({host_a0_i, host_d_i}),
      .dout   (fifo_dout_s),
      .level  (fifo_level_s),
      .full   (fifo_full_s),
      .empty  (fifo_empty_s)
   );

   assign status_busy_s   = opm_status_i[OPM_BUSY_BIT];
   assign unused_status_s = ^opm_status_i;
   assign cnt_zero_s      = (cnt_r == CNT_ZERO);

   // Eligibility and round-robin grant; a grant only happens from IDLE.
   always_comb begin
      host_elig_s = ~fifo_empty_s & (~lock_r | (lock_owner_r == REQ_HOST));
      aux_elig_s  = aux_valid_i & (~lock_r | (lock_owner_r == REQ_AUX));
      grant_s     = 1'b0;
      grant_req_s = REQ_HOST;
      if (state_r == IDLE) begin
         if (host_elig_s && aux_elig_s) begin
            grant_s     = 1'b1;
            grant_req_s = rr_pick(last_req_r);
         end else if (host_elig_s) begin
            grant_s     = 1'b1;
            grant_req_s = REQ_HOST;
         end else if (aux_elig_s) begin
            grant_s     = 1'b1;
            grant_req_s = REQ_AUX;
         end else begin
            grant_s     = 1'b0;
            grant_req_s = REQ_HOST;
         end
      end else begin
         grant_s     = 1'b0;
         grant_req_s = REQ_HOST;
      end
   end

   // Select the granted command, pop on host grant, detect dropped pushes and poll expiry.
   always_comb begin
      if (grant_req_s == REQ_AUX) begin
         grant_cmd_s = {aux_a0_i, aux_d_i};
      end else begin
         grant_cmd_s = fifo_dout_s;
      end
      pop_s         = grant_s & (grant_req_s == REQ_HOST);
      drop_s        = host_wr_i & fifo_full_s & ~pop_s;
      timeout_set_s = (state_r == POLL) & status_busy_s & cnt_zero_s;
   end

   // Write sequencer: grant, strobe timing, post-write gap/settle, busy poll.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r      <= IDLE;
         cnt_r        <= CNT_ZERO;
         cur_cmd_r    <= 9'h000;
         cur_req_r    <= REQ_HOST;
         last_req_r   <= REQ_AUX;
         lock_r       <= 1'b0;
         lock_owner_r <= REQ_HOST;
         aux_ready_r  <= 1'b0;
         cs_n_r       <= 1'b1;
         wr_n_r       <= 1'b1;
         rd_n_r       <= 1'b1;
         a0_r         <= 1'b0;
         d_r          <= 8'h00;
      end else begin
         aux_ready_r <= 1'b0;
         case (state_r)
            IDLE: begin
               cs_n_r <= 1'b1;
               wr_n_r <= 1'b1;
               rd_n_r <= 1'b1;
               a0_r   <= 1'b0;
               d_r    <= 8'h00;
               if (grant_s) begin
                  state_r     <= SETUP;
                  cur_cmd_r   <= grant_cmd_s;
                  cur_req_r   <= grant_req_s;
                  last_req_r  <= grant_req_s;
                  aux_ready_r <= (grant_req_s == REQ_AUX);
                  if (!grant_cmd_s.a0) begin
                     lock_r       <= 1'b1;
                     lock_owner_r <= grant_req_s;
                  end
                  cs_n_r <= 1'b0;
                  a0_r   <= grant_cmd_s.a0;
                  d_r    <= grant_cmd_s.d;
               end
            end
            SETUP: begin
               state_r <= STROBE;
               cnt_r   <= CNT_STROBE;
               wr_n_r  <= 1'b0;
               a0_r    <= cur_cmd_r.a0;
               d_r     <= cur_cmd_r.d;
            end
            STROBE: begin
               if (cnt_zero_s) begin
                  state_r <= HOLD;
                  wr_n_r  <= 1'b1;
               end else begin
                  cnt_r <= cnt_r - CNT_ONE;
               end
            end
            HOLD: begin
               cs_n_r <= 1'b1;
               a0_r   <= 1'b0;
               d_r    <= 8'h00;
               if (cur_cmd_r.a0) begin
                  state_r <= SETTLE;
                  cnt_r   <= CNT_SETTLE;
               end else begin
                  state_r <= GAP;
                  cnt_r   <= CNT_GAP;
               end
            end
            GAP: begin
               if (cnt_zero_s) begin
                  state_r <= IDLE;
               end else begin
                  cnt_r <= cnt_r - CNT_ONE;
               end
            end
            SETTLE: begin
               if (cnt_zero_s) begin
                  state_r <= POLL;
                  cnt_r   <= CNT_POLL;
                  cs_n_r  <= 1'b0;
                  rd_n_r  <= 1'b0;
                  a0_r    <= 1'b0;
               end else begin
                  cnt_r <= cnt_r - CNT_ONE;
               end
            end
            POLL: begin
               if (!status_busy_s) begin
                  state_r <= IDLE;
                  cs_n_r  <= 1'b1;
                  rd_n_r  <= 1'b1;
                  if (lock_r && (lock_owner_r == cur_req_r)) begin
                     lock_r <= 1'b0;
                  end
               end else if (cnt_zero_s) begin
                  // Chip never went ready: give up on this write and free the bus.
                  state_r <= IDLE;
                  cs_n_r  <= 1'b1;
                  rd_n_r  <= 1'b1;
                  lock_r  <= 1'b0;
               end else begin
                  cnt_r <= cnt_r - CNT_ONE;
               end
            end
            default: begin
               state_r <= IDLE;
               lock_r  <= 1'b0;
               cs_n_r  <= 1'b1;
               wr_n_r  <= 1'b1;
               rd_n_r  <= 1'b1;
               a0_r    <= 1'b0;
               d_r     <= 8'h00;
            end
         endcase
      end
   end

   // Sticky error flags; a new event in the same cycle as a clear wins.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ovf_r     <= 1'b0;
         timeout_r <= 1'b0;
      end else begin
         if (drop_s) begin
            ovf_r <= 1'b1;
         end else if (ovf_clr_i) begin
            ovf_r <= 1'b0;
         end else begin
            ovf_r <= ovf_r;
         end
         if (timeout_set_s) begin
            timeout_r <= 1'b1;
         end else if (ovf_clr_i) begin
            timeout_r <= 1'b0;
         end else begin
            timeout_r <= timeout_r;
         end
      end
   end

   assign opm_cs_n_o   = cs_n_r;
   assign opm_wr_n_o   = wr_n_r;
   assign opm_rd_n_o   = rd_n_r;
   assign opm_a0_o     = a0_r;
   assign opm_d_o      = d_r;
   assign aux_ready_o  = aux_ready_r;
   assign host_ovf_o   = ovf_r;
   assign timeout_o    = timeout_r;
   assign host_full_o  = fifo_full_s;
   assign host_level_o = fifo_level_s;
   assign sched_busy_o = (state_r != IDLE) | (fifo_level_s != {LVL_W{1'b0}});

endmodule

// File: tb/tb_opm_wr_sched.sv
// Directed bench for opm_wr_sched. Expected bus writes are queued when the
// stimulus is issued; a negedge monitor pops and compares every completed
// WR strobe, and also checks strobe width and settle-to-poll spacing.
module tb_opm_wr_sched;

   logic       clk = 1'b0;
   logic       resetn = 1'b1;
   logic       host_wr_i = 1'b0;
   logic       host_a0_i = 1'b0;
   logic [7:0] host_d_i = 8'h00;
   logic       host_full_o;
   logic [4:0] host_level_o;
   logic       host_ovf_o;
   logic       ovf_clr_i = 1'b0;
   logic       aux_valid_i = 1'b0;
   logic       aux_a0_i = 1'b0;
   logic [7:0] aux_d_i = 8'h00;
   logic       aux_ready_o;
   logic       opm_cs_n_o;
   logic       opm_wr_n_o;
   logic       opm_rd_n_o;
   logic       opm_a0_o;
   logic [7:0] opm_d_o;
   logic [7:0] opm_status_i = 8'h00;
   logic       sched_busy_o;
   logic       timeout_o;

   int         n_tests = 0;
   int         n_fail = 0;
   int         strobes_seen = 0;
   logic [8:0] sbq [$];

   opm_wr_sched dut (
      .clk          (clk),
      .resetn       (resetn),
      .host_wr_i    (host_wr_i),
      .host_a0_i    (host_a0_i),
      .host_d_i     (host_d_i),
      .host_full_o  (host_full_o),
      .host_level_o (host_level_o),
      .host_ovf_o   (host_ovf_o),
      .ovf_clr_i    (ovf_clr_i),
      .aux_valid_i  (aux_valid_i),
      .aux_a0_i     (aux_a0_i),
      .aux_d_i      (aux_d_i),
      .aux_ready_o  (aux_ready_o),
      .opm_cs_n_o   (opm_cs_n_o),
      .opm_wr_n_o   (opm_wr_n_o),
      .opm_rd_n_o   (opm_rd_n_o),
      .opm_a0_o     (opm_a0_o),
      .opm_d_o      (opm_d_o),
      .opm_status_i (opm_status_i),
      .sched_busy_o (sched_busy_o),
      .timeout_o    (timeout_o)
   );

   always #20 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_host(input logic a0, input logic [7:0] d);
      host_wr_i = 1'b1;
      host_a0_i = a0;
      host_d_i  = d;
      tick();
      host_wr_i = 1'b0;
   endtask

   task automatic wait_rd_low(input int lim);
      int i = 0;
      while (opm_rd_n_o !== 1'b0 && i < lim) begin
         tick();
         i++;
      end
      chk("wait_poll", opm_rd_n_o, 0);
   endtask

   task automatic wait_wr_low(input int lim);
      int i = 0;
      while (opm_wr_n_o !== 1'b0 && i < lim) begin
         tick();
         i++;
      end
      chk("wait_strobe", opm_wr_n_o, 0);
   endtask

   task automatic wait_idle(input int lim);
      int i = 0;
      while (sched_busy_o !== 1'b0 && i < lim) begin
         tick();
         i++;
      end
      chk("wait_idle", sched_busy_o, 0);
   endtask

   task automatic aux_send(input logic a0, input logic [7:0] d, input int lim);
      int i = 0;
      aux_valid_i = 1'b1;
      aux_a0_i    = a0;
      aux_d_i     = d;
      while (aux_ready_o !== 1'b1 && i < lim) begin
         tick();
         i++;
      end
      chk("aux_accept", aux_ready_o, 1);
      aux_valid_i = 1'b0;
      tick();
      chk("aux_ready_pulse", aux_ready_o, 0);
   endtask

   task automatic check_quiet(input string tag);
      chk({tag, "_bus"}, {opm_cs_n_o, opm_wr_n_o, opm_rd_n_o, opm_a0_o, opm_d_o}, 12'hE00);
      chk({tag, "_level"}, host_level_o, 0);
      chk({tag, "_flags"}, {host_full_o, host_ovf_o, timeout_o, aux_ready_o, sched_busy_o}, 0);
   endtask

   // Bus monitor / scoreboard
   logic       mon_in_strobe = 1'b0;
   int         mon_len = 0;
   logic [9:0] mon_cap = 10'h000;
   logic       mon_gap_on = 1'b0;
   int         mon_gap = 0;
   logic [8:0] mon_exp;

   always @(negedge clk) begin
      if (!resetn) begin
         mon_in_strobe = 1'b0;
         mon_gap_on    = 1'b0;
         mon_len       = 0;
         mon_gap       = 0;
      end else begin
         if (!mon_in_strobe && opm_wr_n_o == 1'b0) begin
            mon_in_strobe = 1'b1;
            mon_len       = 1;
            mon_cap       = {opm_cs_n_o, opm_a0_o, opm_d_o};
            chk("strobe_cs_low", opm_cs_n_o, 0);
         end else if (mon_in_strobe && opm_wr_n_o == 1'b0) begin
            mon_len++;
            chk("strobe_stable", {opm_cs_n_o, opm_a0_o, opm_d_o}, mon_cap);
         end else if (mon_in_strobe) begin
            mon_in_strobe = 1'b0;
            strobes_seen++;
            chk("strobe_len", mon_len, 14);
            if (sbq.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL sb_unexpected: got write 0x%0h, expected none", mon_cap[8:0]);
            end else begin
               mon_exp = sbq.pop_front();
               chk("sb_write", {23'd0, mon_cap[8:0]}, {23'd0, mon_exp});
            end
            if (mon_cap[8]) begin
               mon_gap_on = 1'b1;
               mon_gap    = 0;
            end
         end
         if (mon_gap_on) begin
            if (opm_rd_n_o == 1'b0) begin
               chk("poll_start", mon_gap, 15);
               chk("poll_cs_a0", {opm_cs_n_o, opm_a0_o}, 0);
               mon_gap_on = 1'b0;
            end else begin
               mon_gap++;
            end
         end
      end
   end

   initial begin
      int s0;
      int n;

      // Reset
      #5 resetn = 1'b0;
      repeat (3) tick();
      check_quiet("reset");
      resetn = 1'b1;
      tick();

      // Single host pair with exact cycle positions
      opm_status_i = 8'h00;
      sbq.push_back(9'h020);
      sbq.push_back(9'h1C0);
      push_host(1'b0, 8'h20);
      chk("lat_grant_cycle", opm_cs_n_o, 1);
      push_host(1'b1, 8'hC0);
      chk("lat_setup", {opm_cs_n_o, opm_wr_n_o, opm_a0_o, opm_d_o}, {2'b01, 9'h020});
      tick();
      chk("strobe_begin", opm_wr_n_o, 0);
      repeat (14) tick();
      chk("hold", {opm_cs_n_o, opm_wr_n_o}, 2'b01);
      tick();
      chk("gap_cs", opm_cs_n_o, 1);
      repeat (4) tick();
      chk("gap_end_idle", opm_cs_n_o, 1);
      tick();
      chk("data_setup", {opm_cs_n_o, opm_wr_n_o, opm_a0_o, opm_d_o}, {2'b01, 9'h1C0});
      wait_idle(200);
      chk("pair_timeout", timeout_o, 0);

      // Busy wait
      opm_status_i = 8'h80;
      sbq.push_back(9'h155);
      sbq.push_back(9'h040);
      sbq.push_back(9'h100);
      push_host(1'b1, 8'h55);
      push_host(1'b0, 8'h40);
      push_host(1'b1, 8'h00);
      wait_rd_low(100);
      s0 = strobes_seen;
      repeat (100) tick();
      chk("busy_no_issue", strobes_seen, s0);
      chk("busy_still_poll", opm_rd_n_o, 0);
      opm_status_i = 8'h00;
      wait_idle(300);
      chk("busy_resume", strobes_seen, s0 + 2);
      chk("busy_timeout", timeout_o, 0);

      // Overflow
      opm_status_i = 8'h80;
      sbq.push_back(9'h1AA);
      push_host(1'b1, 8'hAA);
      wait_rd_low(100);
      for (int i = 0; i < 17; i++) begin
         push_host(1'b1, 8'h60 + 8'(i));
         if (i < 16) begin
            sbq.push_back({1'b1, 8'h60 + 8'(i)});
         end
         if (i == 15) begin
            chk("ovf_16_level", host_level_o, 16);
            chk("ovf_16_flag", host_ovf_o, 0);
         end
      end
      chk("ovf_17_level", host_level_o, 16);
      chk("ovf_17_full", host_full_o, 1);
      chk("ovf_17_flag", host_ovf_o, 1);
      ovf_clr_i = 1'b1;
      tick();
      ovf_clr_i = 1'b0;
      chk("ovf_clear", host_ovf_o, 0);
      opm_status_i = 8'h00;
      wait_idle(2000);

      // Atomic arbitration: host was granted last, so aux pair goes first
      opm_status_i = 8'h80;
      sbq.push_back(9'h177);
      push_host(1'b1, 8'h77);
      wait_rd_low(100);
      sbq.push_back(9'h028);
      sbq.push_back(9'h14A);
      sbq.push_back(9'h008);
      sbq.push_back(9'h101);
      fork
         begin
            aux_send(1'b0, 8'h28, 600);
            aux_send(1'b1, 8'h4A, 600);
         end
         begin
            push_host(1'b0, 8'h08);
            push_host(1'b1, 8'h01);
            repeat (3) tick();
            opm_status_i = 8'h00;
         end
      join
      wait_idle(600);

      // Timeout: lock must be released and aux served before the next host entry
      opm_status_i = 8'hFF;
      sbq.push_back(9'h014);
      sbq.push_back(9'h133);
      sbq.push_back(9'h15A);
      sbq.push_back(9'h13C);
      push_host(1'b0, 8'h14);
      push_host(1'b1, 8'h33);
      push_host(1'b1, 8'h3C);
      wait_wr_low(50);
      fork
         aux_send(1'b1, 8'h5A, 5000);
         begin
            wait_rd_low(200);
            n = 0;
            while (opm_rd_n_o == 1'b0 && n < 5000) begin
               tick();
               n++;
            end
            chk("poll_len", n, 4096);
            chk("timeout_set", timeout_o, 1);
            opm_status_i = 8'h00;
         end
      join
      wait_idle(300);
      chk("timeout_sticky", timeout_o, 1);
      ovf_clr_i = 1'b1;
      tick();
      ovf_clr_i = 1'b0;
      chk("timeout_clear", timeout_o, 0);

      // Reset in the middle of a strobe
      push_host(1'b0, 8'h50);
      push_host(1'b1, 8'h51);
      wait_wr_low(20);
      repeat (4) tick();
      chk("pre_rst_level", host_level_o, 1);
      #5 resetn = 1'b0;
      #1;
      chk("rst_async_bus", {opm_cs_n_o, opm_wr_n_o}, 2'b11);
      chk("rst_async_level", host_level_o, 0);
      tick();
      tick();
      resetn = 1'b1;
      tick();
      check_quiet("post_rst");
      s0 = strobes_seen;
      repeat (30) tick();
      chk("post_rst_no_write", strobes_seen, s0);
      chk("sb_drained", sbq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global time bound so the run always ends.
   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/opm_wr_sched.md
Name: opm_wr_sched

Overview:
- Write scheduler and arbiter for the YM2151 (IKAOPM) register port.
- Buffers host CPU register writes in a FIFO.
- Shares the OPM bus between the host FIFO and an auxiliary requester, such as a future flash-based music player.
- Issues each write as a timed CS/WR strobe, then polls the OPM status busy flag (bit 7) before the next data write.

Parameters:
- FIFO_DEPTH, 16: host FIFO entries. Power of 2, range 4..64.
- WR_CYCLES, 14: clk cycles WR_n is held low. Covers at least 2 phiM enables at clk/7.
- ADDR_GAP, 4: idle cycles after an address write (A0=0).
- BUSY_SETTLE, 14: cycles after a data write (A0=1) before the first status poll.
- BUSY_TIMEOUT, 4096: maximum poll cycles before the write is abandoned.

Ports:
- clk, in, 1: system clock, 25 MHz.
- resetn, in, 1: asynchronous active-low reset.
- host_wr_i, in, 1: one-cycle push strobe.
- host_a0_i, in, 1: entry register select (0 = address, 1 = data).
- host_d_i, in, 8: entry data byte.
- host_full_o, out, 1: FIFO full.
- host_level_o, out, $clog2(FIFO_DEPTH)+1: FIFO occupancy.
- host_ovf_o, out, 1: sticky; a push was dropped.
- ovf_clr_i, in, 1: clears host_ovf_o and timeout_o.
- aux_valid_i, in, 1: aux request valid.
- aux_a0_i, in, 1: aux register select.
- aux_d_i, in, 8: aux data byte.
- aux_ready_o, out, 1: aux request accepted this cycle.
- opm_cs_n_o, out, 1: OPM chip select.
- opm_wr_n_o, out, 1: OPM write strobe.
- opm_rd_n_o, out, 1: OPM read strobe.
- opm_a0_o, out, 1: OPM A0.
- opm_d_o, out, 8: OPM write data.
- opm_status_i, in, 8: OPM o_D status byte.
- sched_busy_o, out, 1: FIFO non-empty or a write in flight.
- timeout_o, out, 1: sticky busy-poll timeout.

Behaviour:
- Reset, asynchronous, effective immediately:
  - cs_n, wr_n and rd_n = 1; a0 = 0; d = 0x00.
  - FIFO empty; level = 0; full = 0.
  - ovf, timeout, aux_ready and sched_busy = 0.
  - Lock cleared; FSM in IDLE.
  - A reset mid-strobe aborts the write; no partial state survives.
- FIFO push:
  - host_wr_i with level < FIFO_DEPTH pushes {a0,d}.
  - A push at full is also accepted if the same cycle pops.
  - Otherwise the push is dropped and host_ovf_o is set.
  - host_ovf_o and timeout_o clear only on ovf_clr_i. If set and clear coincide, set wins.
- Arbitration, evaluated in IDLE:
  - Round-robin between FIFO non-empty and aux_valid_i. The last granted requester gets lower priority.
  - A granted entry with A0=0 sets lock with owner = that requester.
  - While locked, only the owner is eligible. This keeps address/data pairs atomic.
  - Lock clears when the owner's A0=1 write completes.
  - A second A0=0 from the owner keeps the lock.
  - Grant pops the FIFO, or pulses aux_ready_o for 1 cycle. The entry is latched internally.
- FSM:
  - IDLE: outputs inactive. On grant -> SETUP.
  - SETUP (1 cycle): drive cs_n=0, a0, d; wr_n=1 -> STROBE.
  - STROBE (WR_CYCLES): wr_n=0; cs_n, a0, d stable -> HOLD.
  - HOLD (1 cycle): wr_n=1, cs_n=0, data held. Then A0=0 -> GAP, A0=1 -> SETTLE.
  - GAP (ADDR_GAP): cs_n=1 -> IDLE.
  - SETTLE (BUSY_SETTLE): cs_n=1 -> POLL.
  - POLL: cs_n=0, rd_n=0, a0=0. opm_status_i is sampled every cycle.
    - status[7]=0 -> IDLE; lock cleared if applicable.
    - BUSY_TIMEOUT cycles elapsed -> set timeout_o, clear lock, -> IDLE.
- Latency:
  - Host push to cs_n low: 3 cycles when idle (push, grant, SETUP).
  - Address write, total: 1+WR_CYCLES+1+ADDR_GAP = 20 cycles.
- sched_busy_o = (state != IDLE) | (level != 0).
- Counters are saturating-free down-counters loaded per state. The FIFO pointers wrap modulo FIFO_DEPTH.

Decomposition:
- aura_pkg holds:
  - OPM_BUSY_BIT = 7.
  - The FSM state encoding: IDLE, SETUP, STROBE, HOLD, GAP, SETTLE, POLL.
  - The requester IDs REQ_HOST=0, REQ_AUX=1.
- Sub-module opm_cmd_fifo: synchronous 9-bit x FIFO_DEPTH FIFO.
  - Async active-low reset.
  - Push/pop/level/full/empty.
  - Supports simultaneous push and pop at full.

Test Plan:
- Single host pair: push {0,0x20} then {1,0xC0}, status[7]=0.
  - Two strobes: a0=0 d=0x20, then a0=1 d=0xC0.
  - wr_n low exactly 14 cycles each.
  - Poll starts 14 cycles after the second HOLD.
- Busy wait: hold status=0x80 for 100 poll cycles, then 0x00.
  - The next queued write issues only after status clears.
  - timeout_o stays 0.
- Overflow: push 17 entries back-to-back with OPM held busy.
  - level = 16; host_ovf_o = 1 after the 17th.
  - ovf_clr_i clears it.
- Atomic arbitration: host pushes {0,0x08},{1,0x01} while aux presents {0,0x28},{1,0x4A} simultaneously.
  - Bus order is a complete pair then the other pair; no interleaving.
  - The second pair goes to the non-last-granted requester.
- Timeout: status stuck at 0xFF.
  - timeout_o set after 4096 POLL cycles; lock released.
  - Aux is granted next.
- Reset mid-STROBE: assert resetn=0 at STROBE cycle 5.
  - wr_n and cs_n go to 1 in the same cycle.
  - level = 0; outputs as in reset after release.
